// File: rtl/mult32x32_fast_ctrl.sv
// mult32x32_fast_ctrl
//   Sequencer for a 32x32 multiplier built from 8x16 partial products.
//   Each compute step selects one byte of a (a_sel) and one 16-bit word
//   of b (b_sel), the matching shift (shift_sel), and asks the datapath
//   to accumulate (upd_prod). The product register is cleared in the
//   cycle a new operation is accepted (clr_prod).
//
//   Build option: define MULT_FAST_SKIP_EN to let the zero flags
//   (a_msb_is_0, b_msw_is_0) skip partial products that are known zero.
//   Without it the flags are ignored and every operation takes 8 steps.
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   start            request a multiplication (ignored while busy)
//   a_msb_is_0       a[31:24] == 0
//   b_msw_is_0       b[31:16] == 0
//   busy             high in every compute state
//   done             one-cycle pulse, product final in that cycle
//   a_sel, b_sel     operand slice selects for the current step
//   shift_sel        partial-product shift for the current step
//   upd_prod         accumulate this cycle
//   clr_prod         clear product register this cycle (start in IDLE)
//   last_steps       step count of the most recently completed operation
module mult32x32_fast_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       a_msb_is_0,
    input  logic       b_msw_is_0,
    output logic       busy,
    output logic       done,
    output logic [1:0] a_sel,
    output logic       b_sel,
    output logic [5:0] shift_sel,
    output logic       upd_prod,
    output logic       clr_prod,
    output logic [3:0] last_steps
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        A0B0 = 4'd1,
        A1B0 = 4'd2,
        A2B0 = 4'd3,
        A3B0 = 4'd4,
        A0B1 = 4'd5,
        A1B1 = 4'd6,
        A2B1 = 4'd7,
        A3B1 = 4'd8
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] step_cnt;

    // Byte index of a for a compute state.
    function automatic logic [1:0] a_idx(input state_t s);
        case (s)
            A1B0, A1B1: a_idx = 2'd1;
            A2B0, A2B1: a_idx = 2'd2;
            A3B0, A3B1: a_idx = 2'd3;
            default:    a_idx = 2'd0;
        endcase
    endfunction

    // Word index of b for a compute state.
    function automatic logic b_idx(input state_t s);
        case (s)
            A0B1, A1B1, A2B1, A3B1: b_idx = 1'b1;
            default:                b_idx = 1'b0;
        endcase
    endfunction

`ifndef MULT_FAST_SKIP_EN
    // Flags have no effect in the fixed-order build.
    logic unused_flags;
    assign unused_flags = a_msb_is_0 ^ b_msw_is_0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = A0B0;
            A0B0: state_nxt = A1B0;
            A1B0: state_nxt = A2B0;
`ifdef MULT_FAST_SKIP_EN
            A2B0: begin
                if (!a_msb_is_0)      state_nxt = A3B0;
                else if (!b_msw_is_0) state_nxt = A0B1;
                else                  state_nxt = IDLE;
            end
            A3B0: state_nxt = b_msw_is_0 ? IDLE : A0B1;
            A2B1: state_nxt = a_msb_is_0 ? IDLE : A3B1;
`else
            A2B0: state_nxt = A3B0;
            A3B0: state_nxt = A0B1;
            A2B1: state_nxt = A3B1;
`endif
            A0B1: state_nxt = A1B1;
            A1B1: state_nxt = A2B1;
            A3B1: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            step_cnt   <= 4'd0;
            last_steps <= 4'd0;
            done       <= 1'b0;
            busy       <= 1'b0;
            upd_prod   <= 1'b0;
            a_sel      <= 2'd0;
            b_sel      <= 1'b0;
            shift_sel  <= 6'd0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            upd_prod  <= (state_nxt != IDLE);
            a_sel     <= a_idx(state_nxt);
            b_sel     <= b_idx(state_nxt);
            shift_sel <= {1'b0, a_idx(state_nxt), 3'b000} + {1'b0, b_idx(state_nxt), 4'b0000};
            done      <= (state != IDLE) && (state_nxt == IDLE);

            if (state == IDLE) begin
                if (start) step_cnt <= 4'd0;
            end else if (upd_prod) begin
                step_cnt <= step_cnt + 4'd1;
            end

            // The final step is still being counted, hence the +1.
            if ((state != IDLE) && (state_nxt == IDLE))
                last_steps <= step_cnt + 4'd1;
        end
    end

    assign clr_prod = (state == IDLE) && start;

endmodule
